psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Sits directly downstream of a PE and drains its psum FIFO.
- Adds each local psum to the matching psum arriving from the PE row below (vertical accumulation).
- Buffers results in a small output FIFO and forwards them up the column or to the global buffer.
- Counts results per pass, then signals done once the last result has left the block.

Parameters:
- ADDER_WIDTH, 32, width of psum data on all three data paths.
- CONFIG_BIT, 5, width of the out_count configuration input.
- OUT_DEPTH, 4, depth of the internal output FIFO (power of 2, at least 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; when low, all state is frozen.
- start  input  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- first_row  input  1  sampled at start; 1 means no upstream psum, so local psums pass through unchanged.
- out_count  input  CONFIG_BIT  psums per pass; sampled at start.
- pe_psum_empty  input  1  PE psum FIFO empty flag.
- pe_psum_din  input  ADDER_WIDTH  head of the PE psum FIFO (show-ahead); valid whenever pe_psum_empty=0.
- pe_psum_ren  output  1  pops the PE psum FIFO.
- up_valid  input  1  upstream psum valid.
- up_data  input  ADDER_WIDTH  upstream psum.
- up_ready  output  1  upstream psum consumed this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  ADDER_WIDTH  accumulated psum (head of the output FIFO).
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset: state=IDLE; count=0; output FIFO empty. Outputs pe_psum_ren, up_ready, out_valid, busy and done are all 0; out_data=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and en=1: latch first_row and out_count, clear count.
  - Next state is RUN, or DONE directly if out_count=0.
  - start outside IDLE is ignored.
- RUN, fire condition: fire = en & ~pe_psum_empty & (first_row_q | up_valid) & ~ofifo_full.
- RUN, on fire (all in the same cycle):
  - pe_psum_ren=1.
  - up_ready=~first_row_q.
  - Push sum into the output FIFO: sum = pe_psum_din + (first_row_q ? 0 : up_data).
  - count increments.
- Sum arithmetic: truncated to ADDER_WIDTH, wraps modulo 2^ADDER_WIDTH; no saturation.
- pe_psum_ren and up_ready are combinational from fire. They are never asserted without a push, and never asserted outside RUN.
- RUN exit: the fire with count==out_count_q-1 moves to DRAIN.
- DRAIN: waits until the output FIFO is empty (including a pop in the current cycle), then moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: a value pushed into an empty FIFO appears on out_valid/out_data the next cycle (registered FIFO, 1-cycle push-to-out).
- Output pop: occurs when out_valid & out_ready & en.
- Simultaneous push and pop: allowed whenever the FIFO is not full.
- Full FIFO: no push even if a pop occurs in the same cycle (no full-FIFO pass-through). This costs one bubble.
- Ordering: results leave the FIFO in push order; the FIFO pointers wrap modulo OUT_DEPTH.
- en=0: no fire, no pop, out_valid forced 0; FSM state, count and FIFO contents are held.
- Upstream psum with up_valid=1 while pe_psum_empty=1: held, not consumed (up_ready=0).
- Local psum available while up_valid=0 and first_row_q=0: not popped.
- rstn low mid-pass: immediate return to the reset state; buffered psums are discarded.

Test Plan:
- first_row=1, out_count=3; PE FIFO holds 5, 7, 9; out_ready=1 → out_data sequence 5, 7, 9; three pe_psum_ren pulses; up_ready never 1; done pulses once after the last pop; busy then drops.
- first_row=0, out_count=2; PE provides 10, 20; upstream provides 1, 2 → outputs 11, 22; pe_psum_ren and up_ready pulse together exactly twice.
- Backpressure: out_ready=0, out_count=6, both sources always valid → exactly 4 (OUT_DEPTH) pushes, then fire stalls; raise out_ready → remaining 2 results follow in order; done only after the FIFO is empty.
- Source skew: up_valid arrives 3 cycles after ~pe_psum_empty → no pe_psum_ren for 3 cycles; fire on the cycle up_valid rises.
- Wrap and edge cases:
  - pe_psum_din=0xFFFFFFFF, up_data=2 → out_data=0x00000001.
  - out_count=0 → done 1 cycle after start, with no pops.
- Disturbance:
  - en=0 for 2 cycles mid-RUN → no pops or pushes and out_valid=0; the pass resumes afterwards.
  - rstn pulse mid-RUN → all outputs 0 and state IDLE.
  - start during RUN is ignored.

Source files
------------

// File: rtl/psum_accumulator.sv
// Vertical psum accumulator: drains the local PE psum FIFO, adds the psum from the row below,
// and forwards results through a small registered output FIFO, pulsing done once a pass has fully left.
module psum_accumulator #(
   parameter int ADDER_WIDTH = 32,
   parameter int CONFIG_BIT  = 5,
   parameter int OUT_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   start,
   input  logic                   first_row,
   input  logic [CONFIG_BIT-1:0]  out_count,
   input  logic                   pe_psum_empty,
   input  logic [ADDER_WIDTH-1:0] pe_psum_din,
   output logic                   pe_psum_ren,
   input  logic                   up_valid,
   input  logic [ADDER_WIDTH-1:0] up_data,
   output logic                   up_ready,
   output logic                   out_valid,
   output logic [ADDER_WIDTH-1:0] out_data,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | accumulating and pushing out_count results
   // DRAIN | all results pushed, waiting for the output FIFO to empty
   // DONE  | one-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam int PW = $clog2(OUT_DEPTH);
   localparam int CW = PW + 1;

   state_t                  state_q, state_d;
   logic                    first_row_q;
   logic [CONFIG_BIT-1:0]   out_count_q;
   logic [CONFIG_BIT-1:0]   count_q;
   logic [ADDER_WIDTH-1:0]  mem_q [OUT_DEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           occ_q;
   logic                    ofifo_full, ofifo_empty;
   logic                    fire, pop, load;
   logic [ADDER_WIDTH-1:0]  sum;

   assign ofifo_full  = (occ_q == CW'(OUT_DEPTH));
   assign ofifo_empty = (occ_q == '0);

   // Full FIFO blocks the push even if a pop happens this cycle.
   assign fire = (state_q == S_RUN) & en & ~pe_psum_empty & (first_row_q | up_valid) & ~ofifo_full;
   assign pop  = out_valid & out_ready;
   assign sum  = pe_psum_din + (first_row_q ? '0 : up_data);

   assign pe_psum_ren = fire;
   assign up_ready    = fire & ~first_row_q;
   assign out_valid   = en & ~ofifo_empty;
   assign out_data    = ofifo_empty ? '0 : mem_q[rd_ptr_q];
   assign busy        = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && en) begin
               load    = 1'b1;
               state_d = (out_count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (fire && (count_q == out_count_q - CONFIG_BIT'(1)))
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (en && (ofifo_empty || ((occ_q == CW'(1)) && pop)))
               state_d = S_DONE;
         end
         S_DONE: begin
            done = en;
            if (en)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         first_row_q <= 1'b0;
         out_count_q <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            first_row_q <= first_row;
            out_count_q <= out_count;
            count_q     <= '0;
         end else if (fire) begin
            count_q <= count_q + CONFIG_BIT'(1);
         end
         if (fire)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (fire && !pop)
            occ_q <= occ_q + CW'(1);
         else if (!fire && pop)
            occ_q <= occ_q - CW'(1);
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (fire)
         mem_q[wr_ptr_q] <= sum;
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator, checked against a queue-based transaction model
// plus directed passes with fixed expected outputs.
module tb_psum_accumulator;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rstn;
   logic        en;
   logic        start;
   logic        first_row;
   logic [4:0]  out_count;
   logic        pe_psum_empty;
   logic [31:0] pe_psum_din;
   logic        pe_psum_ren;
   logic        up_valid;
   logic [31:0] up_data;
   logic        up_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        done;

   psum_accumulator #(.ADDER_WIDTH(32), .CONFIG_BIT(5), .OUT_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .en(en), .start(start), .first_row(first_row),
      .out_count(out_count), .pe_psum_empty(pe_psum_empty), .pe_psum_din(pe_psum_din),
      .pe_psum_ren(pe_psum_ren), .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: source queues, expected results in push order, pass phase
   logic [31:0] pe_q[$];
   logic [31:0] up_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] out_log[$];
   int ph;          // 0 idle, 1 pushing, 2 draining, 3 done pulse
   int occ;
   int pushes;
   int n_q;
   bit fr_q;
   int done_seen, ren_cnt, upr_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0; occ = 0; pushes = 0; n_q = 0; fr_q = 1'b0;
      pe_q.delete(); up_q.delete(); exp_q.delete();
   endtask

   task automatic cycle(input bit st, input bit fr_in, input int n_in,
                        input int p_pe, input int p_up, input int p_rdy, input int p_en,
                        input bit rdy_off, input bit up_off);
      bit          exp_fire, exp_pop;
      logic [31:0] tmp;
      @(negedge clk);
      start     = st;
      first_row = st ? fr_in : 1'($urandom);
      out_count = st ? n_in[4:0] : 5'($urandom);
      en        = st ? 1'b1 : ($urandom_range(99) < p_en);
      pe_psum_empty = !(pe_q.size() > 0 && $urandom_range(99) < p_pe);
      pe_psum_din   = (pe_q.size() > 0) ? pe_q[0] : $urandom;
      if (fr_q && ph != 0) begin
         up_valid = 1'($urandom);
         up_data  = $urandom;
      end else begin
         up_valid = !up_off && up_q.size() > 0 && ($urandom_range(99) < p_up);
         up_data  = (up_q.size() > 0) ? up_q[0] : $urandom;
      end
      out_ready = !rdy_off && ($urandom_range(99) < p_rdy);
      #1;
      exp_fire = (ph == 1) && en && !pe_psum_empty && (fr_q || up_valid) && (occ < DEPTH);
      exp_pop  = en && (occ > 0) && out_ready;
      check("busy",        32'(busy),        32'(ph != 0));
      check("pe_psum_ren", 32'(pe_psum_ren), 32'(exp_fire));
      check("up_ready",    32'(up_ready),    32'(exp_fire && !fr_q));
      check("out_valid",   32'(out_valid),   32'(en && occ > 0));
      check("done",        32'(done),        32'(ph == 3 && en));
      if (occ > 0)
         check("out_data", out_data, exp_q[0]);
      if (pe_psum_ren) ren_cnt++;
      if (up_ready) upr_cnt++;
      if (done) done_seen++;
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (exp_pop) begin
         tmp = exp_q.pop_front();
         occ--;
      end
      if (exp_fire) begin
         tmp = fr_q ? pe_q[0] : pe_q[0] + up_q[0];
         exp_q.push_back(tmp);
         tmp = pe_q.pop_front();
         if (!fr_q) tmp = up_q.pop_front();
         occ++;
         pushes++;
      end
      case (ph)
         0: if (st) begin
               fr_q = fr_in; n_q = n_in; pushes = 0;
               ph = (n_in == 0) ? 3 : 1;
            end
         1: if (exp_fire && pushes == n_q) ph = 2;
         2: if (en && occ == 0) ph = 3;
         3: if (en) ph = 0;
         default: ph = 0;
      endcase
   endtask

   task automatic run_pass(input bit fr, input int n, input int p_pe, input int p_up,
                           input int p_rdy, input int p_en, input int rdy_hold,
                           input int up_hold, input bit noise);
      int k;
      done_seen = 0; ren_cnt = 0; upr_cnt = 0;
      out_log.delete();
      cycle(1'b1, fr, n, p_pe, p_up, p_rdy, p_en, 1'b0, 1'b0);
      k = 0;
      while (ph != 0 && k < 3000) begin
         cycle(noise && ($urandom_range(99) < 10), fr, n, p_pe, p_up, p_rdy, p_en,
               k < rdy_hold, k < up_hold);
         k++;
      end
      start = 1'b0;
      check("pass_timeout", 32'(ph), 32'd0);
      check("done_count",   32'(done_seen), 32'd1);
      check("results_left", 32'(exp_q.size()), 32'd0);
      check("pop_count",    32'(out_log.size()), 32'(n));
   endtask

   task automatic fill(input bit fr, input int n);
      for (int i = 0; i < n; i++) begin
         pe_q.push_back($urandom);
         if (!fr) up_q.push_back($urandom);
      end
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; start = 1'b0; first_row = 1'b0; out_count = '0;
      pe_psum_empty = 1'b1; pe_psum_din = '0; up_valid = 1'b0; up_data = '0; out_ready = 1'b0;
      model_reset();
      #1;
      check("rst_ren",      32'(pe_psum_ren), 32'd0);
      check("rst_up_ready", 32'(up_ready),    32'd0);
      check("rst_out_valid",32'(out_valid),   32'd0);
      check("rst_out_data", out_data,         32'd0);
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_done",     32'(done),        32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // first row pass-through
      pe_q = '{32'd5, 32'd7, 32'd9};
      run_pass(1'b1, 3, 100, 100, 100, 100, 0, 0, 1'b0);
      check("fr_ren_cnt", 32'(ren_cnt), 32'd3);
      check("fr_upr_cnt", 32'(upr_cnt), 32'd0);
      if (out_log.size() == 3) begin
         check("fr_out0", out_log[0], 32'd5);
         check("fr_out1", out_log[1], 32'd7);
         check("fr_out2", out_log[2], 32'd9);
      end

      // vertical accumulation
      pe_q = '{32'd10, 32'd20};
      up_q = '{32'd1, 32'd2};
      run_pass(1'b0, 2, 100, 100, 100, 100, 0, 0, 1'b0);
      check("acc_ren_cnt", 32'(ren_cnt), 32'd2);
      check("acc_upr_cnt", 32'(upr_cnt), 32'd2);
      if (out_log.size() == 2) begin
         check("acc_out0", out_log[0], 32'd11);
         check("acc_out1", out_log[1], 32'd22);
      end

      // backpressure: consumer stalled until the FIFO fills
      fill(1'b0, 6);
      run_pass(1'b0, 6, 100, 100, 100, 100, 10, 0, 1'b0);

      // upstream arrives late
      fill(1'b0, 2);
      run_pass(1'b0, 2, 100, 100, 100, 100, 0, 3, 1'b0);

      // wraparound sum
      pe_q = '{32'hFFFF_FFFF};
      up_q = '{32'd2};
      run_pass(1'b0, 1, 100, 100, 100, 100, 0, 0, 1'b0);
      if (out_log.size() == 1)
         check("wrap_out", out_log[0], 32'h0000_0001);

      // empty pass
      run_pass(1'b1, 0, 100, 100, 100, 100, 0, 0, 1'b0);
      check("zero_ren_cnt", 32'(ren_cnt), 32'd0);

      // enable toggling and start noise
      fill(1'b0, 5);
      run_pass(1'b0, 5, 100, 100, 100, 70, 0, 0, 1'b1);

      // reset mid-pass with results buffered
      fill(1'b1, 8);
      cycle(1'b1, 1'b1, 8, 100, 100, 100, 100, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b1, 8, 100, 100, 0, 100, 1'b1, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_ren",       32'(pe_psum_ren), 32'd0);
      check("mid_rst_up_ready",  32'(up_ready),    32'd0);
      check("mid_rst_out_valid", 32'(out_valid),   32'd0);
      check("mid_rst_out_data",  out_data,         32'd0);
      check("mid_rst_busy",      32'(busy),        32'd0);
      check("mid_rst_done",      32'(done),        32'd0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;

      // randomized passes
      for (int p = 0; p < 20; p++) begin
         bit fr;
         int n;
         fr = 1'($urandom);
         n  = $urandom_range(12);
         fill(fr, n);
         run_pass(fr, n, $urandom_range(100, 30), $urandom_range(100, 30),
                  $urandom_range(100, 20), $urandom_range(100, 60),
                  $urandom_range(6), $urandom_range(4), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
